// File: rtl/mac_result_serializer.sv
// Buffers completed MAC result words in a small FIFO and streams each one out
// LSB-first as bytes over an 8-bit valid/ready port.
module mac_result_serializer #(
    parameter int RESULT_W = 21,
    parameter int DEPTH    = 4,
    localparam int NBYTES  = (RESULT_W + 7) / 8,
    localparam int PTR_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [RESULT_W-1:0] result_in,
    input  logic                result_valid,
    input  logic                clear_ovf,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic                byte_last,
    output logic [PTR_W:0]      fifo_count,
    output logic                overflow,
    output logic                state_dbg
);

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready.
    // Once byte_valid rises, byte_out/byte_last hold until that transfer; valid only
    // drops after a transfer (or on reset).

    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [RESULT_W-1:0] mem [DEPTH];
    logic [PTR_W:0]      wr_ptr_q;
    logic [PTR_W:0]      rd_ptr_q;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;

    logic [RESULT_W-1:0] word_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [NBYTES*8-1:0] padded;
    logic [7:0]          byte_sel;

    // Extra pointer MSB tells a full FIFO (MSBs differ) from an empty one.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign fifo_count = wr_ptr_q - rd_ptr_q;

    // A same-cycle pop frees a slot, so a full FIFO can still take the new word.
    assign push = result_valid && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[PTR_W-1:0]] <= result_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (result_valid && fifo_full && !pop) begin
            overflow <= 1'b1;
        end else if (clear_ovf) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (byte_ready) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d = idx_q + 1'b1;
                    end else if (!fifo_empty) begin
                        pop   = 1'b1;
                        idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (pop) begin
                word_q <= mem[rd_ptr_q[PTR_W-1:0]];
            end
        end
    end

    // The top byte of the word is zero-filled above RESULT_W.
    always_comb begin
        padded                 = '0;
        padded[RESULT_W-1:0]   = word_q;
        byte_sel               = '0;
        for (int b = 0; b < NBYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                byte_sel = padded[b*8 +: 8];
            end
        end
    end

    assign byte_valid = (state_q == SEND);
    assign byte_out   = byte_valid ? byte_sel : 8'h00;
    assign byte_last  = byte_valid && (idx_q == LAST_IDX);
    assign state_dbg  = (state_q == SEND);

endmodule

// File: tb/tb_mac_result_serializer.sv
// Directed bench for mac_result_serializer: driver tasks push expected bytes into a
// queue, a negedge monitor pops and compares every accepted byte.
module tb_mac_result_serializer;

    localparam int RESULT_W = 21;
    localparam int DEPTH    = 4;

    logic                clk;
    logic                rst;
    logic [RESULT_W-1:0] result_in;
    logic                result_valid;
    logic                clear_ovf;
    logic [7:0]          byte_out;
    logic                byte_valid;
    logic                byte_ready;
    logic                byte_last;
    logic [2:0]          fifo_count;
    logic                overflow;
    logic                state_dbg;

    logic [8:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int words_sent = 0;
    int words_done = 0;

    logic       prev_stall;
    logic [7:0] prev_byte;
    logic       prev_last;

    mac_result_serializer #(.RESULT_W(RESULT_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .result_in    (result_in),
        .result_valid (result_valid),
        .clear_ovf    (clear_ovf),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .byte_last    (byte_last),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic push_word(input logic [RESULT_W-1:0] w);
        exp_q.push_back({1'b0, w[7:0]});
        exp_q.push_back({1'b0, w[15:8]});
        exp_q.push_back({1'b1, 3'b000, w[20:16]});
    endtask

    // Drives a one-cycle strobe; returns 1 time unit after the capturing edge.
    task automatic drive_word(input logic [RESULT_W-1:0] w, input bit accepted);
        result_in    = w;
        result_valid = 1'b1;
        if (accepted) begin
            push_word(w);
            words_sent++;
        end
        @(posedge clk);
        #1;
        result_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold", {23'd0, byte_valid, byte_last, byte_out},
                      {23'd0, 1'b1, prev_last, prev_byte});
            end
            if (byte_valid && byte_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got %0h expected no byte at %0t", byte_out, $time);
                end else begin
                    check("byte", {23'd0, byte_last, byte_out}, {23'd0, exp_q.pop_front()});
                end
                if (byte_last) begin
                    words_done++;
                end
            end
            prev_stall = byte_valid && !byte_ready;
            prev_byte  = byte_out;
            prev_last  = byte_last;
        end
    end

    initial begin
        int cyc;
        rst          = 1'b1;
        result_in    = '0;
        result_valid = 1'b0;
        clear_ovf    = 1'b0;
        byte_ready   = 1'b1;
        prev_stall   = 1'b0;
        prev_byte    = '0;
        prev_last    = 1'b0;

        #2;
        check("rst_valid", {31'd0, byte_valid}, 32'd0);
        check("rst_out", {24'd0, byte_out}, 32'd0);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: single word, latency, then a zero word
        drive_word(21'h1ABCDE, 1'b1);
        check("t1_lat_valid0", {31'd0, byte_valid}, 32'd0);
        check("t1_count1", {29'd0, fifo_count}, 32'd1);
        cycles(1);
        check("t1_lat_valid1", {31'd0, byte_valid}, 32'd1);
        check("t1_byte0", {24'd0, byte_out}, 32'hDE);
        cycles(3);
        check("t1_idle_valid", {31'd0, byte_valid}, 32'd0);
        check("t1_idle_state", {31'd0, state_dbg}, 32'd0);
        check("t1_idle_count", {29'd0, fifo_count}, 32'd0);
        drive_word(21'h000000, 1'b1);
        cycles(5);

        // 2: fill while stalled, drop the sixth, drain back-to-back
        byte_ready = 1'b0;
        drive_word(21'h000001, 1'b1);
        drive_word(21'h000002, 1'b1);
        drive_word(21'h000003, 1'b1);
        drive_word(21'h000004, 1'b1);
        drive_word(21'h000005, 1'b1);
        check("t2_count_full", {29'd0, fifo_count}, 32'd4);
        check("t2_ovf_clear", {31'd0, overflow}, 32'd0);
        drive_word(21'h000006, 1'b0);
        check("t2_ovf_set", {31'd0, overflow}, 32'd1);
        check("t2_count_after_drop", {29'd0, fifo_count}, 32'd4);
        byte_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check("t2_no_gap", {31'd0, byte_valid}, 32'd1);
            cycles(1);
        end
        check("t2_drained_valid", {31'd0, byte_valid}, 32'd0);
        check("t2_drained_count", {29'd0, fifo_count}, 32'd0);

        // 3: stall mid-word, then clear overflow
        drive_word(21'h155AA3, 1'b1);
        cycles(2);
        byte_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycles(1);
            check("t3_stall_valid", {31'd0, byte_valid}, 32'd1);
            check("t3_stall_byte", {24'd0, byte_out}, 32'h5A);
            check("t3_stall_last", {31'd0, byte_last}, 32'd0);
        end
        byte_ready = 1'b1;
        cycles(4);
        check("t3_ovf_sticky", {31'd0, overflow}, 32'd1);
        clear_ovf = 1'b1;
        cycles(1);
        clear_ovf = 1'b0;
        check("t3_ovf_cleared", {31'd0, overflow}, 32'd0);

        // 4: strobe while full on the cycle the last byte is accepted
        byte_ready = 1'b0;
        drive_word(21'h0A0B0C, 1'b1);
        drive_word(21'h1F0102, 1'b1);
        drive_word(21'h0FFFFF, 1'b1);
        drive_word(21'h155555, 1'b1);
        drive_word(21'h000080, 1'b1);
        check("t4_count_full", {29'd0, fifo_count}, 32'd4);
        byte_ready = 1'b1;
        cycles(2);
        check("t4_last_shown", {31'd0, byte_last}, 32'd1);
        drive_word(21'h1FFFFF, 1'b1);
        byte_ready = 1'b0;
        check("t4_count_same", {29'd0, fifo_count}, 32'd4);
        check("t4_no_ovf", {31'd0, overflow}, 32'd0);
        byte_ready = 1'b1;
        cycles(20);
        check("t4_drained_count", {29'd0, fifo_count}, 32'd0);
        check("t4_drained_q", exp_q.size(), 32'd0);

        // 5: async reset during byte 1 with two words queued
        byte_ready = 1'b0;
        drive_word(21'h123456, 1'b1);
        drive_word(21'h0F0F0F, 1'b1);
        drive_word(21'h1E1E1E, 1'b1);
        check("t5_count", {29'd0, fifo_count}, 32'd2);
        byte_ready = 1'b1;
        cycles(1);
        byte_ready = 1'b0;
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_rst_valid", {31'd0, byte_valid}, 32'd0);
        check("t5_rst_out", {24'd0, byte_out}, 32'd0);
        check("t5_rst_last", {31'd0, byte_last}, 32'd0);
        check("t5_rst_count", {29'd0, fifo_count}, 32'd0);
        check("t5_rst_state", {31'd0, state_dbg}, 32'd0);
        cycles(1);
        rst = 1'b0;
        words_sent = words_done;
        byte_ready = 1'b1;
        cycles(10);
        check("t5_quiet_valid", {31'd0, byte_valid}, 32'd0);
        check("t5_quiet_count", {29'd0, fifo_count}, 32'd0);
        drive_word(21'h0C0FFE, 1'b1);
        cycles(6);

        // 6: random ready and strobes, only when acceptance is guaranteed
        for (int i = 0; i < 4000; i++) begin
            byte_ready = ($urandom_range(0, 3) != 0);
            if (($urandom_range(0, 1) == 1) && ((words_sent - words_done) < DEPTH)) begin
                result_in    = RESULT_W'($urandom);
                result_valid = 1'b1;
                push_word(result_in);
                words_sent++;
            end
            cycles(1);
            result_valid = 1'b0;
        end
        byte_ready = 1'b1;
        cyc = 0;
        while ((exp_q.size() != 0) && (cyc < 100)) begin
            cycles(1);
            cyc++;
        end
        check("t6_drain_in_time", {31'd0, (cyc < 100)}, 32'd1);
        check("t6_no_ovf", {31'd0, overflow}, 32'd0);
        cycles(2);
        check("t6_idle_valid", {31'd0, byte_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
